// File: rtl/batch_alu_sequencer_pkg.sv
// Shared types and constants for the batch ALU sequencer.
// States, fixed register-file indices and the terminator opcode.
package batch_alu_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_OP,
        EXEC,
        WB,
        DONE
    } state_t;

    localparam int REG_A  = 0;
    localparam int REG_B  = 1;
    localparam int REG_OP = 2;

    // Terminator is all-ones in the low OPW bits; sliced to width at use.
    localparam logic [31:0] TERM_ALL = '1;

endpackage

// File: rtl/batch_alu_sequencer_if.sv
// Control, RAM, ALU and register-file bus of the batch ALU sequencer.
// master is the sequencer side, slave is the environment side.
interface batch_alu_sequencer_if #(
    parameter int DW  = 32,
    parameter int AW  = 8,
    parameter int RW  = 6,
    parameter int OPW = 5
);
    logic           start;
    logic           abort;
    logic           busy;
    logic           done;
    logic [7:0]     op_count;
    logic [AW-1:0]  ram_raddr;
    logic [DW-1:0]  ram_rdata;
    logic           ram_wen;
    logic [AW-1:0]  ram_waddr;
    logic [DW-1:0]  ram_wdata;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_out;
    logic           reg_wen;
    logic [RW-1:0]  reg_waddr;
    logic [DW-1:0]  reg_wdata;

    modport master (
        input  start, abort, ram_rdata, alu_out,
        output busy, done, op_count,
        output ram_raddr, ram_wen, ram_waddr, ram_wdata,
        output alu_a, alu_b, alu_op,
        output reg_wen, reg_waddr, reg_wdata
    );

    modport slave (
        output start, abort, ram_rdata, alu_out,
        input  busy, done, op_count,
        input  ram_raddr, ram_wen, ram_waddr, ram_wdata,
        input  alu_a, alu_b, alu_op,
        input  reg_wen, reg_waddr, reg_wdata
    );

endinterface

// File: rtl/batch_alu_sequencer.sv
// Batch sequencer: reads operand pairs and opcodes from RAM, drives an
// external ALU, writes results back to RAM and mirrors operands to regs.
module batch_alu_sequencer
    import batch_alu_sequencer_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 8,
    parameter int RW      = 6,
    parameter int OPW     = 5,
    parameter int A_BASE  = 0,
    parameter int OP_BASE = 100,
    parameter int W_BASE  = 200,
    parameter int MAX_OPS = 50
) (
    input logic                   clk,
    input logic                   rst,
    batch_alu_sequencer_if.master bus
);

    state_t        state;
    state_t        state_nxt;
    logic          load;
    logic          is_term;
    logic [AW-1:0] a_ptr;
    logic [AW-1:0] op_ptr;
    logic [AW-1:0] w_ptr;
    logic [7:0]    count;

    assign is_term      = bus.ram_rdata[OPW-1:0] == TERM_ALL[OPW-1:0];
    assign bus.busy     = state != IDLE;
    assign bus.done     = state == DONE;
    assign bus.op_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        bus.ram_raddr = '0;
        bus.ram_wen   = 1'b0;
        bus.ram_waddr = '0;
        bus.ram_wdata = '0;
        unique case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = RD_A;
                    load      = 1'b1;
                end
            end
            RD_A: begin
                bus.ram_raddr = a_ptr;
                state_nxt     = RD_B;
            end
            RD_B: begin
                bus.ram_raddr = a_ptr + AW'(1);
                state_nxt     = RD_OP;
            end
            RD_OP: begin
                bus.ram_raddr = op_ptr;
                state_nxt     = EXEC;
            end
            EXEC: begin
                state_nxt = is_term ? DONE : WB;
            end
            WB: begin
                bus.ram_wen   = 1'b1;
                bus.ram_waddr = w_ptr;
                bus.ram_wdata = bus.alu_out;
                if ((count + 8'd1) == 8'(MAX_OPS)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD_A;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (bus.abort && state != IDLE && state != DONE) begin
            state_nxt = DONE;
        end
    end

    // Every load below is skipped on abort so an aborted batch leaves
    // operands, pointers and op_count as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ptr         <= '0;
            op_ptr        <= '0;
            w_ptr         <= '0;
            count         <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.reg_wen   <= 1'b0;
            bus.reg_waddr <= '0;
            bus.reg_wdata <= '0;
        end else begin
            bus.reg_wen <= 1'b0;
            if (load) begin
                a_ptr  <= AW'(A_BASE);
                op_ptr <= AW'(OP_BASE);
                w_ptr  <= AW'(W_BASE);
                count  <= '0;
            end
            if (!bus.abort) begin
                if (state == RD_B) begin
                    bus.alu_a     <= bus.ram_rdata;
                    bus.reg_wen   <= 1'b1;
                    bus.reg_waddr <= RW'(REG_A);
                    bus.reg_wdata <= bus.ram_rdata;
                end
                if (state == RD_OP) begin
                    bus.alu_b     <= bus.ram_rdata;
                    bus.reg_wen   <= 1'b1;
                    bus.reg_waddr <= RW'(REG_B);
                    bus.reg_wdata <= bus.ram_rdata;
                end
                if (state == EXEC && !is_term) begin
                    bus.alu_op    <= bus.ram_rdata[OPW-1:0];
                    bus.reg_wen   <= 1'b1;
                    bus.reg_waddr <= RW'(REG_OP);
                    bus.reg_wdata <= {{(DW-OPW){1'b0}}, bus.ram_rdata[OPW-1:0]};
                end
                if (state == WB) begin
                    a_ptr  <= a_ptr + AW'(2);
                    op_ptr <= op_ptr + AW'(1);
                    w_ptr  <= w_ptr + AW'(1);
                    count  <= count + 8'd1;
                end
            end
        end
    end

endmodule
